// File: rtl/multicycle_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared encodings for the multi-cycle RV32 control path: FSM state codes,
// major opcodes, ALU operation codes, ALU operand select codes, and the
// bundle of datapath control strobes produced by the FSM output decode.
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

  // FSM state encodings (4-bit, also exported on state_dbg)
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_ALU_WB   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WB   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  // Supported major opcodes (instruction[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // alu_op codes consumed by the ALU control decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand selects
  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_REG  = 2'b01;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Datapath control strobes driven by the FSM (memory requests excluded,
  // they travel on the memory interface)
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
// Request/ready handshake between the control FSM and the unified memory port.
//   mem_read  : read request  (FSM -> memory)
//   mem_write : write request (FSM -> memory)
//   mem_ready : access completes in any cycle it is high while requested
// Modports: master = control FSM, slave = memory.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_read, output mem_write, input  mem_ready);
  modport slave  (input  mem_read, input  mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_fsm_perf_counters.sv
// -----------------------------------------------------------------------------
// ctrl_perf_counters
// Cycle and retired-instruction counters for the multi-cycle control FSM.
// Both wrap modulo 2^CNT_W and clear on reset.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cycle_en      : count this clock as an active cycle
//   retire        : one instruction retires on this clock
//   cycle_count   : active-cycle counter
//   instret_count : retired-instruction counter
// -----------------------------------------------------------------------------
module ctrl_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cycle_en,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (cycle_en) cycle_count   <= cycle_count + CNT_W'(1);
      if (retire)   instret_count <= instret_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Main control FSM of the multi-cycle RV32 core. Sequences the shared ALU,
// IR, PC and unified memory port for R-type (add/sub/or/and), lw, sw and
// beq; anything else ends in the absorbing TRAP state.
//
// Parameters:
//   CNT_W           width of the performance counters
//   TRAP_ON_INVFUNC 1: invalid R-type funct traps; 0: completes as a NOP
// Macro:
//   PERF_CNT_EN     when defined, cycle_count/instret_count are live
//                   counters; otherwise both ports are tied to 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            instruction[6:0] from the IR
//   inv_func          invalid-function flag from the ALU control decoder
//   bus (master)      mem_read/mem_write requests, mem_ready handshake
//   iord              address select (0 = PC, 1 = ALUOut)
//   ir_write          IR load enable
//   pc_write          unconditional PC write
//   pc_write_cond     PC write qualified by ALU zero
//   pc_source         0 = ALU result, 1 = ALUOut
//   alu_src_a/b       ALU operand selects
//   alu_op            00 add, 01 sub, 10 funct-decoded
//   reg_write         register file write enable
//   mem_to_reg        writeback select (0 = ALUOut, 1 = MDR)
//   illegal           sticky trap flag
//   state_dbg         current state encoding
//   cycle_count       active-cycle counter
//   instret_count     retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter int TRAP_ON_INVFUNC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             opcode,
  input  logic                   inv_func,
  multicycle_ctrl_fsm_if.master  bus,
  output logic                   iord,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   pc_source,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   illegal,
  output logic [3:0]             state_dbg,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       instret_count
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  ctrl_t      ctrl;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; combinational blocks below use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: every always_comb target gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:          state_nxt = S_EXEC_R;
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_BRANCH:         state_nxt = S_BRANCH;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        if (!inv_func)                 state_nxt = S_ALU_WB;
        else if (TRAP_ON_INVFUNC != 0) state_nxt = S_TRAP;
        else                           state_nxt = S_FETCH;   // NOP: skip writeback
      end
      S_ALU_WB:   state_nxt = S_FETCH;
      // IR still holds the instruction, so opcode picks load vs store here
      S_MEM_ADDR: state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   if (bus.mem_ready) state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_TRAP;   // unused encodings are treated as faults
    endcase
  end

  // Output decode: Moore except ir_write/pc_write in FETCH, which follow
  // mem_ready so the IR and PC update exactly on the completing cycle.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = 1'b0;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = SRC_A_REG;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
      end
      S_TRAP:  ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign illegal       = ctrl.illegal;
  assign state_dbg     = state;

`ifdef PERF_CNT_EN
  logic cycle_en;
  logic retire;

  assign cycle_en = (state != S_IDLE) && (state != S_TRAP);
  // Any entry into FETCH from a non-FETCH, non-IDLE state ends an instruction:
  // ALU_WB, MEM_WB, MEM_WR, BRANCH, or the EXEC_R NOP path.
  assign retire   = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

  ctrl_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .cycle_en      (cycle_en),
    .retire        (retire),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Directed, table-driven bench for multicycle_ctrl_fsm. Two instances share
// stimulus: dut_t (TRAP_ON_INVFUNC=1) and dut_n (TRAP_ON_INVFUNC=0), both with
// 4-bit counters. Inputs change on the falling edge; outputs are sampled 1
// time unit later, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;
  import rv_ctrl_pkg::*;

  localparam int TB_CNT_W = 4;

  typedef struct {
    logic [6:0]  opcode;
    logic        inv_func;
    logic        mem_ready;
    logic [3:0]  state;
    logic [15:0] outs;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       inv_func;
  logic       mem_ready;

  int tests;
  int fails;

  multicycle_ctrl_fsm_if bus_t ();
  multicycle_ctrl_fsm_if bus_n ();
  assign bus_t.mem_ready = mem_ready;
  assign bus_n.mem_ready = mem_ready;

  logic                iord_t, ir_write_t, pc_write_t, pc_write_cond_t, pc_source_t;
  logic [1:0]          alu_src_a_t, alu_src_b_t, alu_op_t;
  logic                reg_write_t, mem_to_reg_t, illegal_t;
  logic [3:0]          state_t;
  logic [TB_CNT_W-1:0] cyc_t, ret_t;

  logic                iord_n, ir_write_n, pc_write_n, pc_write_cond_n, pc_source_n;
  logic [1:0]          alu_src_a_n, alu_src_b_n, alu_op_n;
  logic                reg_write_n, mem_to_reg_n, illegal_n;
  logic [3:0]          state_n;
  logic [TB_CNT_W-1:0] cyc_n, ret_n;

  multicycle_ctrl_fsm #(.CNT_W(TB_CNT_W), .TRAP_ON_INVFUNC(1)) dut_t (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .inv_func (inv_func),
    .bus (bus_t),
    .iord (iord_t), .ir_write (ir_write_t), .pc_write (pc_write_t),
    .pc_write_cond (pc_write_cond_t), .pc_source (pc_source_t),
    .alu_src_a (alu_src_a_t), .alu_src_b (alu_src_b_t), .alu_op (alu_op_t),
    .reg_write (reg_write_t), .mem_to_reg (mem_to_reg_t), .illegal (illegal_t),
    .state_dbg (state_t), .cycle_count (cyc_t), .instret_count (ret_t)
  );

  multicycle_ctrl_fsm #(.CNT_W(TB_CNT_W), .TRAP_ON_INVFUNC(0)) dut_n (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .inv_func (inv_func),
    .bus (bus_n),
    .iord (iord_n), .ir_write (ir_write_n), .pc_write (pc_write_n),
    .pc_write_cond (pc_write_cond_n), .pc_source (pc_source_n),
    .alu_src_a (alu_src_a_n), .alu_src_b (alu_src_b_n), .alu_op (alu_op_n),
    .reg_write (reg_write_n), .mem_to_reg (mem_to_reg_n), .illegal (illegal_n),
    .state_dbg (state_n), .cycle_count (cyc_n), .instret_count (ret_n)
  );

  // Packed view: {rd, wr, iord, irw, pcw, pcwc, pcs, src_a, src_b, alu_op, rw, m2r, ill}
  logic [15:0] outs_t, outs_n;
  assign outs_t = {bus_t.mem_read, bus_t.mem_write, iord_t, ir_write_t, pc_write_t,
                   pc_write_cond_t, pc_source_t, alu_src_a_t, alu_src_b_t, alu_op_t,
                   reg_write_t, mem_to_reg_t, illegal_t};
  assign outs_n = {bus_n.mem_read, bus_n.mem_write, iord_n, ir_write_n, pc_write_n,
                   pc_write_cond_n, pc_source_n, alu_src_a_n, alu_src_b_n, alu_op_n,
                   reg_write_n, mem_to_reg_n, illegal_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic rd, input logic wr, input logic io,
                                     input logic irw, input logic pcw, input logic pcwc,
                                     input logic pcs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic rw, input logic m2r, input logic ill);
    return {rd, wr, io, irw, pcw, pcwc, pcs, a, b, op, rw, m2r, ill};
  endfunction

  function automatic vec_t mv(input logic [6:0] op, input logic inv, input logic rdy,
                              input logic [3:0] st, input logic [15:0] e);
    vec_t v;
    v.opcode = op; v.inv_func = inv; v.mem_ready = rdy; v.state = st; v.outs = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected output patterns, written from the per-state output tables
  logic [15:0] e_zero, e_fetch_w, e_fetch_r, e_decode, e_exec_r, e_alu_wb;
  logic [15:0] e_mem_addr, e_mem_rd, e_mem_wb, e_mem_wr, e_branch, e_trap;
  logic [TB_CNT_W-1:0] perf_scale;

  // Apply one vector to the shared inputs, check dut_t, advance one clock
  task automatic apply_check(input string tag, input vec_t v);
    opcode    = v.opcode;
    inv_func  = v.inv_func;
    mem_ready = v.mem_ready;
    #1;
    check({tag, " state"}, 32'(state_t), 32'(v.state));
    check({tag, " outs"},  32'(outs_t),  32'(v.outs));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Async reset for 3 cycles; returns at a falling edge with both DUTs in FETCH
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    inv_func  = 1'b0;
    opcode    = 7'd0;
    #1;
    check({tag, " rst state"}, 32'(state_t), 32'(S_IDLE));
    check({tag, " rst outs"},  32'(outs_t),  32'(e_zero));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, " idle outs"}, 32'(outs_t), 32'(e_zero));
    check({tag, " idle cyc"},  32'(cyc_t),  32'd0);
    check({tag, " idle ret"},  32'(ret_t),  32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs [0:20];
  vec_t rvec [0:3];

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    opcode    = 7'd0;
    inv_func  = 1'b0;
    mem_ready = 1'b0;

`ifdef PERF_CNT_EN
    perf_scale = TB_CNT_W'(1);
`else
    perf_scale = TB_CNT_W'(0);
`endif

    e_zero     = 16'h0000;
    e_fetch_r  = pk(1,0,0,1,1,0,0, 2'b00, 2'b01, 2'b00, 0,0,0);
    e_fetch_w  = pk(1,0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0,0,0);
    e_decode   = pk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 0,0,0);
    e_exec_r   = pk(0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b10, 0,0,0);
    e_alu_wb   = pk(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0,0);
    e_mem_addr = pk(0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 0,0,0);
    e_mem_rd   = pk(1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0);
    e_mem_wb   = pk(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,1,0);
    e_mem_wr   = pk(0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,0);
    e_branch   = pk(0,0,0,0,0,1,1, 2'b01, 2'b00, 2'b01, 0,0,0);
    e_trap     = pk(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0,1);

    // R-type add, lw with 2 waits, sw with 1 wait, beq with a fetch wait
    vecs[0]  = mv(OP_RTYPE,  0, 0, S_FETCH,    e_fetch_w);
    vecs[1]  = mv(OP_RTYPE,  0, 1, S_FETCH,    e_fetch_r);
    vecs[2]  = mv(OP_RTYPE,  0, 1, S_DECODE,   e_decode);
    vecs[3]  = mv(OP_RTYPE,  0, 1, S_EXEC_R,   e_exec_r);
    vecs[4]  = mv(OP_RTYPE,  0, 1, S_ALU_WB,   e_alu_wb);
    vecs[5]  = mv(OP_LOAD,   0, 1, S_FETCH,    e_fetch_r);
    vecs[6]  = mv(OP_LOAD,   0, 1, S_DECODE,   e_decode);
    vecs[7]  = mv(OP_LOAD,   0, 1, S_MEM_ADDR, e_mem_addr);
    vecs[8]  = mv(OP_LOAD,   0, 0, S_MEM_RD,   e_mem_rd);
    vecs[9]  = mv(OP_LOAD,   0, 0, S_MEM_RD,   e_mem_rd);
    vecs[10] = mv(OP_LOAD,   0, 1, S_MEM_RD,   e_mem_rd);
    vecs[11] = mv(OP_LOAD,   0, 0, S_MEM_WB,   e_mem_wb);
    vecs[12] = mv(OP_STORE,  0, 1, S_FETCH,    e_fetch_r);
    vecs[13] = mv(OP_STORE,  0, 1, S_DECODE,   e_decode);
    vecs[14] = mv(OP_STORE,  0, 1, S_MEM_ADDR, e_mem_addr);
    vecs[15] = mv(OP_STORE,  0, 0, S_MEM_WR,   e_mem_wr);
    vecs[16] = mv(OP_STORE,  0, 1, S_MEM_WR,   e_mem_wr);
    vecs[17] = mv(OP_BRANCH, 0, 1, S_FETCH,    e_fetch_r);
    vecs[18] = mv(OP_BRANCH, 0, 1, S_DECODE,   e_decode);
    vecs[19] = mv(OP_BRANCH, 0, 1, S_BRANCH,   e_branch);
    vecs[20] = mv(OP_RTYPE,  0, 0, S_FETCH,    e_fetch_w);

    rvec[0] = mv(OP_RTYPE, 0, 1, S_FETCH,  e_fetch_r);
    rvec[1] = mv(OP_RTYPE, 0, 1, S_DECODE, e_decode);
    rvec[2] = mv(OP_RTYPE, 0, 1, S_EXEC_R, e_exec_r);
    rvec[3] = mv(OP_RTYPE, 0, 1, S_ALU_WB, e_alu_wb);

    // Reset/start and the main instruction mix
    do_reset("start");
    for (int i = 0; i < 21; i++) apply_check($sformatf("vec%0d", i), vecs[i]);

    // Illegal opcode: TRAP is absorbing regardless of mem_ready
    do_reset("ill");
    apply_check("ill fetch",  mv(7'b0010011, 0, 1, S_FETCH,  e_fetch_r));
    apply_check("ill decode", mv(7'b0010011, 0, 1, S_DECODE, e_decode));
    for (int i = 0; i < 20; i++)
      apply_check($sformatf("trap%0d", i),
                  mv(7'(OP_RTYPE), 1'(i % 3 == 0), 1'(i % 2), S_TRAP, e_trap));
    check("trap cyc frozen", 32'(cyc_t), 32'(perf_scale * TB_CNT_W'(2)));

    // Invalid funct: dut_t traps, dut_n completes as a NOP without reg_write
    do_reset("inv");
    apply_check("inv fetch",  mv(OP_RTYPE, 0, 1, S_FETCH,  e_fetch_r));
    apply_check("inv decode", mv(OP_RTYPE, 0, 1, S_DECODE, e_decode));
    opcode   = OP_RTYPE;
    inv_func = 1'b1;
    #1;
    check("inv exec state_t", 32'(state_t), 32'(S_EXEC_R));
    check("inv exec outs_n",  32'(outs_n),  32'(e_exec_r));
    @(posedge clk);
    @(negedge clk);
    inv_func  = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("inv trap state_t", 32'(state_t),   32'(S_TRAP));
    check("inv trap illegal", 32'(illegal_t), 32'd1);
    check("inv nop state_n",  32'(state_n),   32'(S_FETCH));
    check("inv nop outs_n",   32'(outs_n),    32'(e_fetch_w));
    check("inv nop ret_n",    32'(ret_n),     32'(perf_scale));
    check("inv nop cyc_n",    32'(cyc_n),     32'(perf_scale * TB_CNT_W'(3)));
    check("inv trap ret_t",   32'(ret_t),     32'd0);
    check("inv trap cyc_t",   32'(cyc_t),     32'(perf_scale * TB_CNT_W'(3)));

    // Counters: 5 back-to-back R-types (20 cycles), then one stalled fetch
    do_reset("perf");
    for (int n = 0; n < 5; n++)
      for (int k = 0; k < 4; k++) apply_check($sformatf("perf%0d.%0d", n, k), rvec[k]);
    check("perf ret 5",     32'(ret_t), 32'(perf_scale * TB_CNT_W'(5)));
    check("perf cyc wrap4", 32'(cyc_t), 32'(perf_scale * TB_CNT_W'(4)));
    apply_check("perf stall", mv(OP_RTYPE, 0, 0, S_FETCH, e_fetch_w));
    check("perf cyc 5",     32'(cyc_t), 32'(perf_scale * TB_CNT_W'(5)));

    // Reset while a fetch is outstanding drops mem_read immediately
    mem_ready = 1'b0;
    #1;
    check("mid pre rd", 32'(bus_t.mem_read), 32'd1);
    do_reset("mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so a stuck run still ends with a report
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
